attitude_sample_sequencer: RTL and testbench
============================================

# attitude_sample_sequencer

Periodically fetches roll and pitch words from the shared IMU register-read port, then encodes and debounces them into a stable 4-bit attitude code for the display logic. It sits between the IMU register reader, which it shares through a request/ack handshake, and the attitude display. It owns the read scheduling, the timeout recovery and the hysteresis against threshold chatter.

## Interface
- SAMPLE_DIV, 500000: clock cycles between sample starts (100 Hz at 50 MHz); ≥ 8.
- TIMEOUT_CYCLES, 1024: maximum cycles a read request may wait for ack.
- STABLE_COUNT, 3: consecutive identical new codes required before o_Attitude changes; ≥ 1.
- ROLL_ADDR, 8'h1C / PITCH_ADDR, 8'h1E: IMU register addresses.
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Enable  in  1  allows new sample sequences to start.
- i_Err_Clr  in  1  clears sticky error flags.
- o_Rd_Req  out  1  read request to register reader.
- o_Rd_Addr  out  8  register address; stable while o_Rd_Req high.
- i_Rd_Ack  in  1  one-cycle ack; i_Rd_Data valid in the same cycle.
- i_Rd_Data  in  16  signed two's-complement angle, 1/16 deg per LSB.
- o_Roll_Raw, o_Pitch_Raw  out  16 each  last committed sample pair.
- o_Sample_Valid  out  1  one-cycle pulse on commit.
- o_Attitude  out  4  debounced code: [sgn(roll), sgn(pitch), over(roll), over(pitch)].
- o_Attitude_Changed  out  1  one-cycle pulse when o_Attitude changes.
- o_Timeout_Err, o_Overrun  out  1 each  sticky error flags.

## Operation
- Free-running divider counts 0..SAMPLE_DIV-1. It runs in every state, including while disabled. tick = (count == SAMPLE_DIV-1).
- FSM states: S_IDLE, S_RD_ROLL, S_RD_PITCH, S_COMMIT.
  - S_IDLE: on tick && i_Enable, go to S_RD_ROLL.
  - S_RD_ROLL: o_Rd_Req=1, addr=ROLL_ADDR. On ack, capture roll into a holding register and go to S_RD_PITCH.
  - S_RD_PITCH: o_Rd_Req=1, addr=PITCH_ADDR. On ack, capture pitch and go to S_COMMIT.
  - S_COMMIT: one cycle, then S_IDLE.
- Request stays high in a read state until ack. The address changes only on a state change. A back-to-back roll→pitch request with no gap is legal.
- Timeout: a per-read wait counter is cleared on entry to each read state. If it reaches TIMEOUT_CYCLES with no ack:
  - drop req;
  - set o_Timeout_Err;
  - return to S_IDLE;
  - discard the held roll; outputs are unchanged and no valid pulse is issued.
- An ack while o_Rd_Req is low is ignored.
- A tick while not in S_IDLE is dropped and sets o_Overrun. A tick while i_Enable is low is ignored silently.
- Deasserting i_Enable mid-sequence does not abort the sequence.
- Commit: o_Roll_Raw/o_Pitch_Raw take the held pair and o_Sample_Valid pulses.
- Encoding of each axis:
  - sign bit = MSB;
  - over bit = (|raw| >> 4) > 10, computed on 16-bit unsigned |raw|;
  - |16'h8000| = 16'h8000, which gives over=1.
- Debounce, evaluated at commit with cand = encode(pair):
  - cand == o_Attitude: clear count.
  - cand == last_cand ≠ o_Attitude: increment count. When count reaches STABLE_COUNT, load o_Attitude, pulse o_Attitude_Changed, clear count.
  - Otherwise: last_cand = cand, count = 1 (with STABLE_COUNT=1, this updates immediately).
- Sticky flags: i_Err_Clr clears them. A set and a clear in the same cycle: set wins.

## Timing
- Reset values: all outputs 0, o_Attitude=4'b0000, divider=0, state S_IDLE. o_Rd_Req drops asynchronously on reset assertion.
- First tick occurs SAMPLE_DIV cycles after reset release.
- Request rises the cycle after the tick-cycle edge.
- Pitch ack sampled at edge k: S_COMMIT occupies cycle k..k+1. Outputs and pulses update at edge k+1 and pulses last exactly one cycle.
- Minimum sequence: tick → commit in 4 cycles when ack arrives the first cycle of each request.
- A timeout asserts at the edge where wait count = TIMEOUT_CYCLES; o_Rd_Req is low the following cycle.

## Structure
- Package attitude_pkg holds:
  - bit-position constants ATT_SGN_ROLL=3, ATT_SGN_PITCH=2, ATT_OVR_ROLL=1, ATT_OVR_PITCH=0;
  - FRAC_BITS=4 and DEG_THRESHOLD=10;
  - the FSM state enum;
  - function encode_attitude(roll, pitch).
- One sub-module, attitude_debounce: a candidate/count filter with inputs i_Cand and i_Strobe, and outputs o_Attitude and o_Changed.

## Test plan
- SAMPLE_DIV=16, ack 1 cycle after each req, roll=16'h00C0 (12°), pitch=16'hFF00 (-16°), STABLE_COUNT=1 → commit with o_Attitude=4'b0111, o_Attitude_Changed pulse, 4 cycles tick→valid plus ack delays.
- Roll=16'h00A0 (10.0°) and 16'h00B0 (11°) → over bit 0 and 1 respectively; roll=16'h8000 → 4'b1010 with pitch 0.
- STABLE_COUNT=3, alternating candidates 0111/0000 → o_Attitude never changes; three identical 0111 samples → change on the third commit only.
- No ack, TIMEOUT_CYCLES=8 → req drops after 8 cycles, o_Timeout_Err=1, no valid pulse, outputs unchanged; i_Err_Clr clears it; a late ack is ignored.
- Ack delay > SAMPLE_DIV → o_Overrun=1 and the sequence completes normally; i_Err_Clr asserted together with a new overrun → flag stays 1.
- i_Rst_L low while o_Rd_Req high → req and all outputs 0 immediately; normal sampling resumes after release.

Source files
------------

// File: rtl/attitude_pkg.sv
// attitude_pkg
//   Shared definitions for the attitude sample sequencer:
//   - bit positions of the 4-bit attitude code
//   - fixed-point format of the IMU angle words (1/16 degree per LSB)
//   - sequencer FSM state encoding
//   - encode_attitude(): maps a roll/pitch sample pair to the attitude code
package attitude_pkg;

  localparam int ATT_SGN_ROLL  = 3;
  localparam int ATT_SGN_PITCH = 2;
  localparam int ATT_OVR_ROLL  = 1;
  localparam int ATT_OVR_PITCH = 0;

  localparam int FRAC_BITS     = 4;
  localparam int DEG_THRESHOLD = 10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ROLL  = 2'd1,
    S_RD_PITCH = 2'd2,
    S_COMMIT   = 2'd3
  } seq_state_e;

  // 16-bit magnitude; -32768 has no positive counterpart and stays 16'h8000,
  // which as an unsigned value is still well above the threshold.
  function automatic logic [15:0] abs16(input logic [15:0] raw);
    logic [15:0] mag;
    if (raw[15]) begin
      mag = (~raw) + 16'd1;
    end else begin
      mag = raw;
    end
    return mag;
  endfunction

  // Whole-degree magnitude strictly above the threshold.
  function automatic logic axis_over(input logic [15:0] raw);
    logic [15:0] deg;
    deg = abs16(raw) >> FRAC_BITS;
    return (deg > 16'(DEG_THRESHOLD));
  endfunction

  function automatic logic [3:0] encode_attitude(input logic [15:0] roll,
                                                 input logic [15:0] pitch);
    logic [3:0] code;
    code                = 4'b0000;
    code[ATT_SGN_ROLL]  = roll[15];
    code[ATT_SGN_PITCH] = pitch[15];
    code[ATT_OVR_ROLL]  = axis_over(roll);
    code[ATT_OVR_PITCH] = axis_over(pitch);
    return code;
  endfunction

endpackage

// File: rtl/attitude_debounce.sv
// attitude_debounce
//   Candidate/count filter: the published attitude only moves once the same
//   new candidate has been presented STABLE_COUNT times in a row (a strobe
//   carrying the currently published code resets the run).
// Ports:
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Strobe       : one-cycle evaluation strobe (one per committed sample)
//   i_Cand         : candidate code, valid with i_Strobe
//   o_Attitude     : debounced code (registered)
//   o_Changed      : one-cycle pulse when o_Attitude is loaded
module attitude_debounce #(
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Strobe,
  input  logic [3:0] i_Cand,
  output logic [3:0] o_Attitude,
  output logic       o_Changed
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [3:0]    att_q, att_d;
  logic [3:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, chg_d;

  // Next-state of the filter, evaluated only on a strobe.
  always_comb begin
    att_d  = att_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    chg_d  = 1'b0;
    if (i_Strobe) begin
      if (i_Cand == att_q) begin
        cnt_d = {CW{1'b0}};
      end else if (i_Cand == last_q) begin
        if (cnt_q == CNT_LAST) begin
          att_d = i_Cand;
          chg_d = 1'b1;
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        last_d = i_Cand;
        // A new candidate is its own first occurrence; with a run length of
        // one that already qualifies it.
        if (STABLE_COUNT == 1) begin
          att_d = i_Cand;
          chg_d = 1'b1;
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = CW'(1);
        end
      end
    end else begin
      chg_d = 1'b0;
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      att_q  <= 4'b0000;
      last_q <= 4'b0000;
      cnt_q  <= {CW{1'b0}};
      chg_q  <= 1'b0;
    end else begin
      att_q  <= att_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
    end
  end

  assign o_Attitude = att_q;
  assign o_Changed  = chg_q;

endmodule

// File: rtl/attitude_sample_sequencer.sv
// attitude_sample_sequencer
//   Every SAMPLE_DIV cycles (when enabled) reads the roll then pitch word
//   through the shared register-read handshake, commits the pair and feeds
//   its attitude code into the debounce filter. Reads that are not acked
//   within TIMEOUT_CYCLES abandon the sequence; sample ticks that arrive
//   while a sequence is still running are dropped and flagged.
// Ports:
//   i_Clk, i_Rst_L            : clock, asynchronous active-low reset
//   i_Enable                  : allows new sequences to start
//   i_Err_Clr                 : clears the sticky error flags
//   o_Rd_Req, o_Rd_Addr       : read request / register address
//   i_Rd_Ack, i_Rd_Data       : one-cycle ack with data
//   o_Roll_Raw, o_Pitch_Raw   : last committed sample pair
//   o_Sample_Valid            : one-cycle pulse on commit
//   o_Attitude                : debounced attitude code
//   o_Attitude_Changed        : one-cycle pulse when o_Attitude changes
//   o_Timeout_Err, o_Overrun  : sticky error flags
module attitude_sample_sequencer
  import attitude_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter logic [7:0]  ROLL_ADDR      = 8'h1C,
  parameter logic [7:0]  PITCH_ADDR     = 8'h1E
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Enable,
  input  logic        i_Err_Clr,
  output logic        o_Rd_Req,
  output logic [7:0]  o_Rd_Addr,
  input  logic        i_Rd_Ack,
  input  logic [15:0] i_Rd_Data,
  output logic [15:0] o_Roll_Raw,
  output logic [15:0] o_Pitch_Raw,
  output logic        o_Sample_Valid,
  output logic [3:0]  o_Attitude,
  output logic        o_Attitude_Changed,
  output logic        o_Timeout_Err,
  output logic        o_Overrun
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  seq_state_e    state_q;
  logic [DW-1:0] div_q;
  logic [WW-1:0] wait_q;
  logic          req_q;
  logic [7:0]    addr_q;
  logic [15:0]   roll_hold_q, pitch_hold_q;
  logic [15:0]   roll_q, pitch_q;
  logic          valid_q;
  logic          tmo_q, ovr_q;

  logic          tick_s, timeout_s, overrun_s, strobe_s;
  logic [3:0]    cand_s;

  // Tick, error-set and commit-strobe decode from current state.
  always_comb begin
    tick_s    = (div_q == DIV_LAST);
    overrun_s = tick_s && (state_q != S_IDLE);
    strobe_s  = (state_q == S_COMMIT);
    cand_s    = encode_attitude(roll_hold_q, pitch_hold_q);
    // wait_q counts completed request cycles, so the last allowed cycle is
    // TIMEOUT_CYCLES-1; an ack in that cycle still completes the read.
    if ((state_q == S_RD_ROLL) || (state_q == S_RD_PITCH)) begin
      timeout_s = !i_Rd_Ack && (wait_q == WAIT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Free-running sample divider; keeps counting in every state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      div_q <= {DW{1'b0}};
    end else if (tick_s) begin
      div_q <= {DW{1'b0}};
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Sequencer FSM with registered handshake, sample and error outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      wait_q       <= {WW{1'b0}};
      req_q        <= 1'b0;
      addr_q       <= 8'h00;
      roll_hold_q  <= 16'h0000;
      pitch_hold_q <= 16'h0000;
      roll_q       <= 16'h0000;
      pitch_q      <= 16'h0000;
      valid_q      <= 1'b0;
      tmo_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Set has priority over clear on both sticky flags.
      if (timeout_s) begin
        tmo_q <= 1'b1;
      end else if (i_Err_Clr) begin
        tmo_q <= 1'b0;
      end else begin
        tmo_q <= tmo_q;
      end
      if (overrun_s) begin
        ovr_q <= 1'b1;
      end else if (i_Err_Clr) begin
        ovr_q <= 1'b0;
      end else begin
        ovr_q <= ovr_q;
      end

      case (state_q)
        S_IDLE: begin
          if (tick_s && i_Enable) begin
            state_q <= S_RD_ROLL;
            req_q   <= 1'b1;
            addr_q  <= ROLL_ADDR;
            wait_q  <= {WW{1'b0}};
          end else begin
            req_q   <= 1'b0;
          end
        end
        S_RD_ROLL: begin
          if (i_Rd_Ack) begin
            roll_hold_q <= i_Rd_Data;
            state_q     <= S_RD_PITCH;
            addr_q      <= PITCH_ADDR;
            wait_q      <= {WW{1'b0}};
          end else if (timeout_s) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            roll_hold_q <= 16'h0000;
          end else begin
            wait_q      <= wait_q + WW'(1);
          end
        end
        S_RD_PITCH: begin
          if (i_Rd_Ack) begin
            pitch_hold_q <= i_Rd_Data;
            state_q      <= S_COMMIT;
            req_q        <= 1'b0;
          end else if (timeout_s) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            roll_hold_q  <= 16'h0000;
          end else begin
            wait_q       <= wait_q + WW'(1);
          end
        end
        S_COMMIT: begin
          roll_q  <= roll_hold_q;
          pitch_q <= pitch_hold_q;
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  attitude_debounce #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Strobe   (strobe_s),
    .i_Cand     (cand_s),
    .o_Attitude (o_Attitude),
    .o_Changed  (o_Attitude_Changed)
  );

  assign o_Rd_Req       = req_q;
  assign o_Rd_Addr      = addr_q;
  assign o_Roll_Raw     = roll_q;
  assign o_Pitch_Raw    = pitch_q;
  assign o_Sample_Valid = valid_q;
  assign o_Timeout_Err  = tmo_q;
  assign o_Overrun      = ovr_q;

endmodule

// File: tb/tb_attitude_sample_sequencer.sv
// Testbench for attitude_sample_sequencer. Two instances run in lockstep on
// the same stimulus: dut_a with STABLE_COUNT=1, dut_b with STABLE_COUNT=3.
// Both use SAMPLE_DIV=16 and TIMEOUT_CYCLES=8, so their handshake behaviour
// is identical and only the debounce outputs differ.
module tb_attitude_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, err_clr, ack;
  logic [15:0] rdata;

  logic        req_a, valid_a, chg_a, tmo_a, ovr_a;
  logic [7:0]  addr_a;
  logic [15:0] roll_a, pitch_a;
  logic [3:0]  att_a;

  logic        req_b, valid_b, chg_b, tmo_b, ovr_b;
  logic [7:0]  addr_b;
  logic [15:0] roll_b, pitch_b;
  logic [3:0]  att_b;

  int n_pass  = 0;
  int n_total = 0;

  attitude_sample_sequencer #(
    .SAMPLE_DIV(16), .TIMEOUT_CYCLES(8), .STABLE_COUNT(1),
    .ROLL_ADDR(8'h1C), .PITCH_ADDR(8'h1E)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Err_Clr(err_clr),
    .o_Rd_Req(req_a), .o_Rd_Addr(addr_a), .i_Rd_Ack(ack), .i_Rd_Data(rdata),
    .o_Roll_Raw(roll_a), .o_Pitch_Raw(pitch_a), .o_Sample_Valid(valid_a),
    .o_Attitude(att_a), .o_Attitude_Changed(chg_a),
    .o_Timeout_Err(tmo_a), .o_Overrun(ovr_a)
  );

  attitude_sample_sequencer #(
    .SAMPLE_DIV(16), .TIMEOUT_CYCLES(8), .STABLE_COUNT(3),
    .ROLL_ADDR(8'h1C), .PITCH_ADDR(8'h1E)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Err_Clr(err_clr),
    .o_Rd_Req(req_b), .o_Rd_Addr(addr_b), .i_Rd_Ack(ack), .i_Rd_Data(rdata),
    .o_Roll_Raw(roll_b), .o_Pitch_Raw(pitch_b), .o_Sample_Valid(valid_b),
    .o_Attitude(att_b), .o_Attitude_Changed(chg_b),
    .o_Timeout_Err(tmo_b), .o_Overrun(ovr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request to rise; returns in its first cycle.
  task automatic wait_req();
    int n;
    n = 0;
    while (!req_a && n < 40) begin
      step();
      n++;
    end
    n_total++;
    if (req_a !== 1'b1) $display("FAIL req_start act=%b exp=1 (no request in 40 cycles)", req_a);
    else n_pass++;
  endtask

  // Ack after d idle request cycles; returns in the cycle after the ack edge.
  task automatic serve(input int d, input logic [15:0] v);
    repeat (d) step();
    ack   = 1'b1;
    rdata = v;
    step();
    ack   = 1'b0;
    rdata = 16'hDEAD;
  endtask

  // Full sequence; returns in the cycle where o_Sample_Valid is expected.
  task automatic sample(input int d1, input logic [15:0] v1,
                        input int d2, input logic [15:0] v2);
    wait_req();
    serve(d1, v1);
    serve(d2, v2);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; err_clr = 1'b0; ack = 1'b0; rdata = 16'h0000;
    repeat (3) step();
    n_total++; if (req_a !== 1'b0) $display("FAIL rst_req act=%b exp=0", req_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL rst_valid act=%b exp=0", valid_a); else n_pass++;
    n_total++; if (att_a !== 4'b0000) $display("FAIL rst_att act=%b exp=0000", att_a); else n_pass++;
    n_total++; if (roll_a !== 16'h0000 || pitch_a !== 16'h0000)
      $display("FAIL rst_raw act=%h/%h exp=0000/0000", roll_a, pitch_a); else n_pass++;
    n_total++; if ({tmo_a, ovr_a, chg_a} !== 3'b000)
      $display("FAIL rst_flags act=%b exp=000", {tmo_a, ovr_a, chg_a}); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    repeat (15) step();
    n_total++; if (req_a !== 1'b0) $display("FAIL early_req act=%b exp=0", req_a); else n_pass++;
    step();
    n_total++; if (req_a !== 1'b1) $display("FAIL first_req act=%b exp=1", req_a); else n_pass++;
    n_total++; if (addr_a !== 8'h1C) $display("FAIL roll_addr act=%h exp=1c", addr_a); else n_pass++;
  endtask

  // Continues from the first roll request cycle.
  task automatic test_basic();
    serve(1, 16'h00C0);
    n_total++; if (req_a !== 1'b1 || addr_a !== 8'h1E)
      $display("FAIL pitch_req act=%b/%h exp=1/1e", req_a, addr_a); else n_pass++;
    serve(1, 16'hFF00);
    n_total++; if (valid_a !== 1'b0 || req_a !== 1'b0)
      $display("FAIL commit_cycle act=%b/%b exp=0/0", valid_a, req_a); else n_pass++;
    step();
    n_total++; if (valid_a !== 1'b1) $display("FAIL basic_valid act=%b exp=1", valid_a); else n_pass++;
    n_total++; if (roll_a !== 16'h00C0 || pitch_a !== 16'hFF00)
      $display("FAIL basic_raw act=%h/%h exp=00c0/ff00", roll_a, pitch_a); else n_pass++;
    n_total++; if (att_a !== 4'b0111 || chg_a !== 1'b1)
      $display("FAIL basic_att act=%b/%b exp=0111/1", att_a, chg_a); else n_pass++;
    n_total++; if (att_b !== 4'b0000 || chg_b !== 1'b0)
      $display("FAIL basic_att_b act=%b/%b exp=0000/0", att_b, chg_b); else n_pass++;
    step();
    n_total++; if (valid_a !== 1'b0 || chg_a !== 1'b0)
      $display("FAIL pulse_width act=%b/%b exp=0/0", valid_a, chg_a); else n_pass++;
    n_total++; if (ovr_a !== 1'b0) $display("FAIL basic_ovr act=%b exp=0", ovr_a); else n_pass++;
  endtask

  logic [15:0] enc_roll [4] = '{16'h00A0, 16'h00B0, 16'h8000, 16'h0000};
  logic [15:0] enc_pitch[4] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF50};
  logic [3:0]  enc_exp  [4] = '{4'b0000, 4'b0010, 4'b1010, 4'b0101};

  task automatic test_encode();
    for (int i = 0; i < 4; i++) begin
      sample(1, enc_roll[i], 1, enc_pitch[i]);
      n_total++; if (att_a !== enc_exp[i] || chg_a !== 1'b1)
        $display("FAIL encode_%0d act=%b/%b exp=%b/1", i, att_a, chg_a, enc_exp[i]); else n_pass++;
      n_total++; if (roll_a !== enc_roll[i] || pitch_a !== enc_pitch[i])
        $display("FAIL encode_raw_%0d act=%h/%h exp=%h/%h", i, roll_a, pitch_a, enc_roll[i], enc_pitch[i]);
      else n_pass++;
    end
    n_total++; if (att_b !== 4'b0000) $display("FAIL encode_att_b act=%b exp=0000", att_b); else n_pass++;
  endtask

  // 1 = sample encoding 0111, 0 = sample encoding 0000.
  bit db_pat[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic test_debounce();
    logic [3:0] exp_att;
    logic       exp_chg;
    for (int i = 0; i < 7; i++) begin
      if (db_pat[i]) sample(1, 16'h00C0, 1, 16'hFF00);
      else           sample(1, 16'h0000, 1, 16'h0000);
      exp_att = (i == 6) ? 4'b0111 : 4'b0000;
      exp_chg = (i == 6);
      n_total++; if (att_b !== exp_att || chg_b !== exp_chg)
        $display("FAIL debounce_%0d act=%b/%b exp=%b/%b", i, att_b, chg_b, exp_att, exp_chg); else n_pass++;
    end
    step();
    n_total++; if (chg_b !== 1'b0) $display("FAIL debounce_pulse act=%b exp=0", chg_b); else n_pass++;
  endtask

  task automatic test_timeout();
    int  hi;
    bit  saw_valid;
    wait_req();
    hi = 1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_a) saw_valid = 1'b1;
      if (req_a) hi++;
      else break;
    end
    n_total++; if (hi != 8) $display("FAIL timeout_len act=%0d exp=8 cycles", hi); else n_pass++;
    n_total++; if (tmo_a !== 1'b1 || tmo_b !== 1'b1)
      $display("FAIL timeout_flag act=%b/%b exp=1/1", tmo_a, tmo_b); else n_pass++;
    n_total++; if (roll_a !== 16'h00C0 || pitch_a !== 16'hFF00 || att_a !== 4'b0111 || att_b !== 4'b0111)
      $display("FAIL timeout_hold act=%h/%h/%b/%b exp=00c0/ff00/0111/0111", roll_a, pitch_a, att_a, att_b);
    else n_pass++;
    ack = 1'b1; rdata = 16'h1234;
    step();
    ack = 1'b0; rdata = 16'hDEAD;
    step();
    n_total++; if (saw_valid || valid_a !== 1'b0 || req_a !== 1'b0)
      $display("FAIL late_ack act=%b/%b/%b exp=0/0/0", saw_valid, valid_a, req_a); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_total++; if (tmo_a !== 1'b0) $display("FAIL timeout_clr act=%b exp=0", tmo_a); else n_pass++;
  endtask

  task automatic test_overrun();
    // Sequence spans 16 cycles, so the next tick lands in the commit cycle.
    wait_req();
    serve(7, 16'h0010);
    serve(6, 16'h0020);
    step();
    n_total++; if (valid_a !== 1'b1 || roll_a !== 16'h0010 || pitch_a !== 16'h0020)
      $display("FAIL overrun_commit act=%b/%h/%h exp=1/0010/0020", valid_a, roll_a, pitch_a); else n_pass++;
    n_total++; if (ovr_a !== 1'b1 || ovr_b !== 1'b1 || tmo_a !== 1'b0)
      $display("FAIL overrun_flag act=%b/%b/%b exp=1/1/0", ovr_a, ovr_b, tmo_a); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_total++; if (ovr_a !== 1'b0) $display("FAIL overrun_clr act=%b exp=0", ovr_a); else n_pass++;
    // Same again, with the clear coinciding with the new overrun.
    wait_req();
    serve(7, 16'h0010);
    serve(6, 16'h0020);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_total++; if (ovr_a !== 1'b1 || valid_a !== 1'b1)
      $display("FAIL set_wins act=%b/%b exp=1/1", ovr_a, valid_a); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_enable();
    bit saw_req;
    wait_req();
    en = 1'b0;
    serve(1, 16'h0100);
    serve(1, 16'h0000);
    step();
    n_total++; if (valid_a !== 1'b1 || roll_a !== 16'h0100 || att_a !== 4'b0010)
      $display("FAIL disable_mid act=%b/%h/%b exp=1/0100/0010", valid_a, roll_a, att_a); else n_pass++;
    saw_req = 1'b0;
    repeat (40) begin
      step();
      if (req_a) saw_req = 1'b1;
    end
    n_total++; if (saw_req || ovr_a !== 1'b0)
      $display("FAIL disabled_tick act=%b/%b exp=0/0", saw_req, ovr_a); else n_pass++;
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    wait_req();
    step();
    rst_n = 1'b0;
    #1;
    n_total++; if (req_a !== 1'b0) $display("FAIL async_req act=%b exp=0", req_a); else n_pass++;
    n_total++; if (att_a !== 4'b0000 || att_b !== 4'b0000 || roll_a !== 16'h0000)
      $display("FAIL async_out act=%b/%b/%h exp=0000/0000/0000", att_a, att_b, roll_a); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    sample(1, 16'h00C0, 1, 16'hFF00);
    n_total++; if (valid_a !== 1'b1 || att_a !== 4'b0111 || att_b !== 4'b0000)
      $display("FAIL resume act=%b/%b/%b exp=1/0111/0000", valid_a, att_a, att_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_basic();
    test_encode();
    test_debounce();
    test_timeout();
    test_overrun();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
